// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : operation codes and FSM state encoding shared by the ALU blocks
// Rev 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [3:0] OP_ADD_LS = 4'b0000;
    localparam logic [3:0] OP_BEQ    = 4'b0001;
    localparam logic [3:0] OP_ADD    = 4'b0010;
    localparam logic [3:0] OP_SUB    = 4'b0011;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_OR     = 4'b0101;
    localparam logic [3:0] OP_AND    = 4'b0110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Every code above OP_AND is unassigned.
    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= OP_AND);
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_alu_shifter.sv
// ============================================================================
// seq_alu_shifter : iterative 1-bit-per-cycle left shifter with down counter
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_alu_shifter #(
    parameter int WIDTH = 64,
    parameter int SHW   = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] load_val,
    input  logic [SHW-1:0]   load_cnt,
    output logic             last,
    output logic [WIDTH-1:0] next_acc
);

    logic [WIDTH-1:0] acc;
    logic [SHW-1:0]   cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc <= '0;
            cnt <= '0;
        end else if (load) begin
            acc <= load_val;
            cnt <= load_cnt;
        end else if (step) begin
            acc <= next_acc;
            cnt <= cnt - SHW'(1);
        end
    end

    // The value produced by the step in which cnt==1 is the final result.
    assign next_acc = {acc[WIDTH-2:0], 1'b0};
    assign last     = (cnt == SHW'(1));

endmodule

`default_nettype wire

// File: rtl/seq_alu.sv
// ============================================================================
// seq_alu : multi-cycle execute ALU (ADD/SUB/OR/AND single cycle, iterative SLL)
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SHW   = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       Operation,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             IllegalOp
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    logic [SHW-1:0]   shamt;
    logic             accept;
    logic             legal;
    logic             is_sll;
    logic             sh_load;
    logic             sh_step;
    logic             sh_last;
    logic [WIDTH-1:0] sh_next;
    logic [WIDTH-1:0] alu_out;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign shamt    = B[SHW-1:0];
    assign legal    = op_is_legal(Operation);
    assign is_sll   = (Operation == OP_SLL);
    assign sh_load  = accept && is_sll && (shamt != '0);
    assign sh_step  = (state == SHIFT);

    // Single-cycle datapath; SLL by zero passes A straight through.
    always_comb begin
        alu_out = '0;
        case (Operation)
            OP_ADD_LS, OP_ADD: alu_out = A + B;
            OP_BEQ, OP_SUB:    alu_out = A + ~B + ONE;
            OP_SLL:            alu_out = A;
            OP_OR:             alu_out = A | B;
            OP_AND:            alu_out = A & B;
            default:           alu_out = '0;
        endcase
    end

    seq_alu_shifter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shifter (
        .clk      (clk),
        .reset    (reset),
        .load     (sh_load),
        .step     (sh_step),
        .load_val (A),
        .load_cnt (shamt),
        .last     (sh_last),
        .next_acc (sh_next)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            Result    <= '0;
            Zero      <= 1'b1;
            IllegalOp <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (!legal) begin
                            Result    <= '0;
                            Zero      <= 1'b1;
                            IllegalOp <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else if (is_sll && (shamt != '0)) begin
                            IllegalOp <= 1'b0;
                            state     <= SHIFT;
                        end else begin
                            Result    <= alu_out;
                            Zero      <= (alu_out == '0);
                            IllegalOp <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    if (sh_last) begin
                        Result    <= sh_next;
                        Zero      <= (sh_next == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // Handoff cycle never accepts; the next accept happens from IDLE.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
// ============================================================================
// tb_seq_alu : directed self-checking bench for seq_alu
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_seq_alu;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  Operation = 4'b0000;
    logic [63:0] A = '0;
    logic [63:0] B = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] Result;
    logic        Zero;
    logic        IllegalOp;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_alu dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Operation (Operation),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .Zero      (Zero),
        .IllegalOp (IllegalOp)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op from IDLE; returns edges from accept until out_valid is seen.
    task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         output int lat, output bit busy_ok);
        int guard;
        in_valid  = 1'b1;
        Operation = op;
        A = a;
        B = b;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        A         = ~a;
        B         = ~b;
        Operation = 4'b1111;
        lat     = 1;
        busy_ok = 1'b1;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (in_ready) busy_ok = 1'b0;
        if (!out_valid) chk("timeout_out_valid", 64'(out_valid), 64'd1);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("handoff_out_valid", 64'(out_valid), 64'd0);
        chk("handoff_in_ready", 64'(in_ready), 64'd1);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } vec_t;

    initial begin
        int   lat;
        bit   busy_ok;
        int   seen;
        vec_t vecs[6];

        // Reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_result", Result, 64'd0);
        chk("rst_zero", 64'(Zero), 64'd1);
        chk("rst_illegal", 64'(IllegalOp), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;

        // ADD with held result
        issue(4'b0010, 64'd5, 64'd7, lat, busy_ok);
        chk("add_lat", 64'(lat), 64'd1);
        chk("add_result", Result, 64'd12);
        chk("add_zero", 64'(Zero), 64'd0);
        chk("add_illegal", 64'(IllegalOp), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("add_hold_result", Result, 64'd12);
            chk("add_hold_valid", 64'(out_valid), 64'd1);
        end
        release_out();

        // BEQ compare
        issue(4'b0001, 64'h1234, 64'h1234, lat, busy_ok);
        chk("beq_eq_result", Result, 64'd0);
        chk("beq_eq_zero", 64'(Zero), 64'd1);
        release_out();
        issue(4'b0001, 64'd3, 64'd5, lat, busy_ok);
        chk("beq_ne_result", Result, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("beq_ne_zero", 64'(Zero), 64'd0);
        release_out();

        // SLL timing
        issue(4'b0100, 64'd1, 64'd3, lat, busy_ok);
        chk("sll3_lat", 64'(lat), 64'd4);
        chk("sll3_result", Result, 64'd8);
        chk("sll3_busy", 64'(busy_ok), 64'd1);
        release_out();
        issue(4'b0100, 64'd1, 64'd63, lat, busy_ok);
        chk("sll63_lat", 64'(lat), 64'd64);
        chk("sll63_result", Result, 64'h8000_0000_0000_0000);
        release_out();
        issue(4'b0100, 64'd1, 64'd64, lat, busy_ok);
        chk("sll64_lat", 64'(lat), 64'd1);
        chk("sll64_result", Result, 64'd1);
        release_out();

        // OR / AND / illegal
        issue(4'b0101, 64'hF0, 64'h0F, lat, busy_ok);
        chk("or_result", Result, 64'hFF);
        chk("or_zero", 64'(Zero), 64'd0);
        release_out();
        issue(4'b0110, 64'hF0, 64'h0F, lat, busy_ok);
        chk("and_result", Result, 64'd0);
        chk("and_zero", 64'(Zero), 64'd1);
        release_out();
        issue(4'b1010, 64'd5, 64'd9, lat, busy_ok);
        chk("ill_lat", 64'(lat), 64'd1);
        chk("ill_result", Result, 64'd0);
        chk("ill_flag", 64'(IllegalOp), 64'd1);
        release_out();
        issue(4'b0011, 64'd10, 64'd4, lat, busy_ok);
        chk("post_ill_flag", 64'(IllegalOp), 64'd0);
        chk("post_ill_result", Result, 64'd6);
        release_out();

        // Reset mid-shift, with in_valid asserted while reset is low
        in_valid  = 1'b1;
        Operation = 4'b0100;
        A = 64'd1;
        B = 64'd20;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset     = 1'b0;
        in_valid  = 1'b1;
        Operation = 4'b0010;
        A = 64'd1;
        B = 64'd1;
        @(posedge clk); #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        chk("midrst_result", Result, 64'd0);
        chk("midrst_zero", 64'(Zero), 64'd1);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("midrst_no_valid", 64'(seen), 64'd0);
        issue(4'b0010, 64'd2, 64'd3, lat, busy_ok);
        chk("midrst_next_lat", 64'(lat), 64'd1);
        chk("midrst_next_result", Result, 64'd5);
        release_out();

        // Back-pressure: in_valid held, out_ready toggling
        vecs[0] = '{4'b0010, 64'd10,   64'd20,   64'd30};
        vecs[1] = '{4'b0011, 64'd7,    64'd9,    64'hFFFF_FFFF_FFFF_FFFE};
        vecs[2] = '{4'b0100, 64'd3,    64'd2,    64'd12};
        vecs[3] = '{4'b0101, 64'hA0,   64'h05,   64'hA5};
        vecs[4] = '{4'b0110, 64'hFF,   64'h3C,   64'h3C};
        vecs[5] = '{4'b0000, 64'd100,  64'd1,    64'd101};
        begin
            int  idx;
            int  got;
            bit  acc_now;
            bit  take_now;
            idx = 0;
            got = 0;
            for (int cyc = 0; cyc < 300 && got < 6; cyc++) begin
                in_valid = (idx < 6);
                if (idx < 6) begin
                    Operation = vecs[idx].op;
                    A = vecs[idx].a;
                    B = vecs[idx].b;
                end
                out_ready = ((cyc % 3) != 0);
                acc_now  = in_valid && in_ready;
                take_now = out_valid && out_ready;
                @(posedge clk); #1;
                if (acc_now) idx++;
                if (take_now) begin
                    if (got < 6) chk("bp_result", Result, vecs[got].exp);
                    got++;
                end
            end
            in_valid  = 1'b0;
            out_ready = 1'b0;
            chk("bp_accepted", 64'(idx), 64'd6);
            chk("bp_delivered", 64'(got), 64'd6);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
